imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter LEN_W, default 16: width of the word-count input and the word address.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum idle cycles allowed between bytes before error.
REQ-003 clk  input  1  rising-edge clock; sole clock of the block.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 i_load_start  input  1  one-cycle pulse that starts a load.
REQ-006 i_load_len  input  LEN_W  number of 32-bit words to load; sampled only when i_load_start is accepted.
REQ-007 i_byte_valid  input  1  byte-stream valid.
REQ-008 i_byte_data  input  8  byte-stream data.
REQ-009 o_byte_ready  output  1  byte-stream ready.
REQ-010 o_wen  output  `IM_DATA_BYTES  per-byte instruction-memory write enables; drives if_stage i_wen.
REQ-011 o_wdata  output  32  instruction-memory write data; drives if_stage i_wdata.
REQ-012 o_waddr  output  LEN_W  word address of the current write.
REQ-013 o_core_rst_n  output  1  active-low hold reset for the if/id/ex/mem/wb stages.
REQ-014 o_busy, o_done, o_error  output  1 each  load status flags.

Function
REQ-015 States SHALL be IDLE, RECV, WRITE, CHECK (macro builds only), DONE and ERROR.
REQ-016 A byte SHALL be accepted only in a cycle where i_byte_valid and o_byte_ready are both 1; o_byte_ready SHALL be 1 only in RECV and CHECK.
REQ-017 Bytes SHALL be assembled little-endian: the first accepted byte goes to bits 7:0; a 2-bit byte counter tracks position 0..3.
REQ-018 Acceptance of byte 3 SHALL move the FSM to WRITE; the write SHALL occur in the next cycle (latency 1).
REQ-019 WRITE SHALL last exactly one cycle with o_wen all ones, o_wdata set to the assembled word and o_waddr set to the word index; o_wen SHALL be 0 in every other state.
REQ-020 After WRITE the word index SHALL increment; if it equals len the FSM SHALL go to DONE (or CHECK), otherwise back to RECV.
REQ-021 len = 0 SHALL go from RECV to DONE (or CHECK) in the next cycle with no write.
REQ-022 A timeout counter SHALL run in RECV/CHECK and clear on each accepted byte; reaching TIMEOUT_CYCLES SHALL force ERROR.
REQ-023 i_load_start SHALL be ignored in RECV, WRITE and CHECK.
REQ-024 i_load_start SHALL be accepted in IDLE, DONE and ERROR: enter RECV, clear o_waddr, counters, o_done and o_error, and latch len.
REQ-025 o_core_rst_n SHALL be 1 only in DONE; o_busy SHALL be 1 in RECV, WRITE and CHECK; o_done SHALL be 1 in DONE; o_error SHALL be 1 in ERROR.

Reset
REQ-026 While rst_n = 0 at a rising edge, the state SHALL go to IDLE and o_byte_ready, o_wen, o_wdata, o_waddr, o_core_rst_n, o_busy, o_done and o_error SHALL all be 0.
REQ-027 Reset in mid-load SHALL discard any partial word and issue no further write.

Configuration
REQ-028 Macro IMEM_LOADER_CHECKSUM_EN defined: after the last word the FSM SHALL enter CHECK and accept one byte; if that byte equals the XOR of all data bytes it SHALL go to DONE, otherwise to ERROR; the timeout applies in CHECK.
REQ-029 Macro IMEM_LOADER_CHECKSUM_EN undefined: no CHECK state and no XOR register; the FSM SHALL go directly to DONE.

Structure
REQ-030 The state enum typedef and the default TIMEOUT_CYCLES constant SHALL live in the shared package; `IM_DATA_BYTES SHALL come from defines.sv.
REQ-031 Byte-to-word assembly (shift register plus byte counter) SHALL be a sub-module named imem_loader_word_asm.

Verification
REQ-032 len=2, bytes 13 05 50 00 93 05 10 00 -> write addr0 0x00500513 and addr1 0x00100593, o_wen=F for one cycle each; then o_done=1 and o_core_rst_n=1.
REQ-033 len=0 -> DONE one cycle after start; o_wen never asserted.
REQ-034 len=1, two bytes sent, then i_byte_valid=0 for 1024 cycles -> o_error=1, o_core_rst_n=0, no write.
REQ-035 len=2, rst_n low after 5 bytes -> all outputs 0 and no second write; a new start then writes from addr 0.
REQ-036 i_load_start pulse during RECV -> ignored; o_waddr and byte count unchanged.
REQ-037 Macro defined, len=1, bytes 01 02 03 04 -> checksum byte 04 gives DONE; checksum byte 05 gives ERROR.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
// The CHECK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHECK = 3'd3,
`endif
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  // A new load may begin only once the previous one has finished (or never started).
  function automatic logic accepts_start(state_e s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface imem_loader_if;
  logic       i_byte_valid;
  logic [7:0] i_byte_data;
  logic       o_byte_ready;

  modport master (output i_byte_valid, output i_byte_data, input o_byte_ready);
  modport slave  (input i_byte_valid, input i_byte_data, output o_byte_ready);
endinterface

// File: rtl/defines.sv
// Project-wide defines shared by the core and its loader.
`ifndef IM_DATA_BYTES
`define IM_DATA_BYTES 4
`endif

// File: rtl/imem_loader_word_asm.sv
// Little-endian byte-to-word assembler: first byte lands in bits 7:0.
module imem_loader_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        acc_i,
  input  logic [7:0]  byte_i,
  output logic        last_o,
  output logic [31:0] word_o
);

  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  cnt_q, cnt_d;

  // New bytes enter at the top, so after four shifts byte 0 sits at the bottom.
  assign shreg_d = {byte_i, shreg_q[31:8]};
  assign word_o  = shreg_d;
  assign last_o  = acc_i && (cnt_q == 2'd3);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = 2'd0;
    else if (acc_i) cnt_d = cnt_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 2'd0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    if (acc_i) shreg_q <= shreg_d;
  end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory and holds the core in reset until the image is loaded.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
`ifndef IM_DATA_BYTES
`include "defines.sv"
`endif
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_load_start,
  input  logic [LEN_W-1:0]          i_load_len,
  imem_loader_if.slave              byte_if,
  output logic [`IM_DATA_BYTES-1:0] o_wen,
  output logic [31:0]               o_wdata,
  output logic [LEN_W-1:0]          o_waddr,
  output logic                      o_core_rst_n,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_LAST = ST_CHECK;
`else
  localparam state_e ST_LAST = ST_DONE;
`endif

  state_e                    state_q, state_d;
  logic [LEN_W-1:0]          len_q, len_d, waddr_q, waddr_inc;
  logic [TMO_W-1:0]          tmo_q;
  logic                      ready_q, core_rst_n_q, busy_q, done_q, error_q;
  logic [`IM_DATA_BYTES-1:0] wen_q;
  logic [31:0]               wdata_q, asm_word;
  logic                      accept, asm_acc, asm_last, start_ok, in_wait, tmo_hit;

  assign accept    = byte_if.i_byte_valid && ready_q;
  assign start_ok  = i_load_start && accepts_start(state_q);
  assign asm_acc   = accept && (state_q == ST_RECV);
  assign waddr_inc = waddr_q + LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_wait   = (state_q == ST_RECV) || (state_q == ST_CHECK);
`else
  assign in_wait   = (state_q == ST_RECV);
`endif
  assign tmo_hit   = in_wait && !accept && (tmo_q == TMO_LAST);

  imem_loader_word_asm u_word_asm (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (start_ok),
    .acc_i  (asm_acc),
    .byte_i (byte_if.i_byte_data),
    .last_o (asm_last),
    .word_o (asm_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;

  always_ff @(posedge clk) begin
    if (start_ok)     xor_q <= 8'h00;
    else if (asm_acc) xor_q <= xor_q ^ byte_if.i_byte_data;
  end
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_load_start) begin
          state_d = ST_RECV;
          len_d   = i_load_len;
        end
      end
      ST_RECV: begin
        if (len_q == '0)  state_d = ST_LAST;
        else if (asm_last) state_d = ST_WRITE;
        else if (tmo_hit)  state_d = ST_ERROR;
      end
      ST_WRITE: state_d = (waddr_inc == len_q) ? ST_LAST : ST_RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept)       state_d = (byte_if.i_byte_data == xor_q) ? ST_DONE : ST_ERROR;
        else if (tmo_hit) state_d = ST_ERROR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      waddr_q      <= '0;
      tmo_q        <= '0;
      ready_q      <= 1'b0;
      wen_q        <= '0;
      wdata_q      <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      if (start_ok)                 waddr_q <= '0;
      else if (state_q == ST_WRITE) waddr_q <= waddr_inc;
      tmo_q   <= (in_wait && !accept) ? tmo_q + TMO_W'(1) : '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ready_q <= ((state_d == ST_RECV) && (len_d != '0)) || (state_d == ST_CHECK);
      busy_q  <= (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
`else
      ready_q <= (state_d == ST_RECV) && (len_d != '0);
      busy_q  <= (state_d == ST_RECV) || (state_d == ST_WRITE);
`endif
      wen_q   <= (state_d == ST_WRITE) ? '1 : '0;
      if (asm_last) wdata_q <= asm_word;
      core_rst_n_q <= (state_d == ST_DONE);
      done_q       <= (state_d == ST_DONE);
      error_q      <= (state_d == ST_ERROR);
    end
  end

  assign byte_if.o_byte_ready = ready_q;
  assign o_wen        = wen_q;
  assign o_wdata      = wdata_q;
  assign o_waddr      = waddr_q;
  assign o_core_rst_n = core_rst_n_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_error      = error_q;

endmodule
